ram_dp_param: RTL
=================

// Module: ram_dp_param
// PURPOSE
//  Parametrised simple-dual-port synchronous RAM; successor to the fixed 4x16 single-port RAM.
//  Separate write and read ports run on one clock; read data is registered and qualified by rd_valid.
//  After reset the memory clears itself to zero; init_busy is high until clearing completes.
//  Sits between datapath producers/consumers and replaces the fixed RAM in lab designs.
// PARAMETERS
//  DATA_W     4   data word width in bits (>=1)
//  ADDR_W     4   address width in bits (>=1)
//  DEPTH      16  number of words; must be <= 2**ADDR_W
//  READ_FIRST 1   same-address read+write in one cycle: 1 = return old word, 0 = return new word
// PORTS
//  clk       in   1       clock; all state updates on the rising edge
//  rst_n     in   1       asynchronous active-low reset
//  we        in   1       write enable
//  wr_addr   in   ADDR_W  write address
//  wr_data   in   DATA_W  write data
//  re        in   1       read enable
//  rd_addr   in   ADDR_W  read address
//  rd_data   out  DATA_W  registered read data
//  rd_valid  out  1       rd_data holds the result of the read accepted on the previous cycle
//  init_busy out  1       high while the memory is being cleared; requests are ignored
//  par_err   out  1       PARITY_EN builds only; see CONFIGURATION
// BEHAVIOUR
//  Reset (async assert, rising-edge release): rd_data=0, rd_valid=0, init_busy=1, init_ptr=0, par_err=0.
//  FSM states:
//    INIT: writes 0 to mem[init_ptr] and increments init_ptr each cycle.
//          At init_ptr==DEPTH-1, clears the last word and moves to RUN; init_busy falls on that edge.
//    RUN:  normal operation; stays in RUN until rst_n asserts.
//  INIT lasts exactly DEPTH cycles after reset release. we and re are ignored in INIT; rd_valid stays 0.
//  Write in RUN: if we && wr_addr<DEPTH, mem[wr_addr] <= wr_data. Out-of-range writes are dropped.
//  Read in RUN, latency 1: if re, rd_data <= mem[rd_addr] and rd_valid <= 1; otherwise rd_valid <= 0.
//    rd_data holds its last value when re=0.
//  Out-of-range read (rd_addr>=DEPTH): rd_data <= 0, rd_valid <= 1.
//  Collision (we && re, wr_addr==rd_addr, in range): READ_FIRST=1 returns the old word.
//    READ_FIRST=0 returns wr_data (bypass). The write always completes.
//  Simultaneous read and write to different addresses are independent; full throughput, one of each per cycle.
//  Reset during INIT restarts clearing from address 0.
//  Reset during RUN re-enters INIT; all contents are cleared.
// CONFIGURATION
//  Macro RAM_DP_PARITY_EN:
//    defined: each word stores an extra even-parity bit (^wr_data) computed on write; INIT writes parity 0.
//      On a read, par_err <= (stored parity != ^stored data); it is registered alongside rd_data and valid with rd_valid.
//      For a bypassed read (READ_FIRST=0 collision), par_err <= 0. par_err <= 0 whenever rd_valid <= 0.
//      A sim-only task inject_par_flip(addr) inverts the stored parity bit, for verification.
//    undefined: no parity storage; par_err port present, tied to 0.
// TESTING (defaults DATA_W=4, ADDR_W=4, DEPTH=16 unless noted)
//  1 Release rst_n at t0 -> init_busy=1 for 16 cycles, then 0; read all 16 addresses -> each rd_data=0, rd_valid=1 one cycle after re.
//  2 Write mem[i]=i for i=0..15, then read addresses 0..15 back-to-back -> rd_data=0..15 with 1-cycle latency; rd_valid continuous.
//  3 mem[5]=4'hA; same cycle we=1,wr_addr=5,wr_data=4'h3,re=1,rd_addr=5 -> READ_FIRST=1: rd_data=4'hA; READ_FIRST=0: rd_data=4'h3; next read of 5 -> 4'h3.
//  4 DEPTH=12: write addr 13 with 4'hF, read 13 -> rd_data=0, rd_valid=1; mem[0..11] unchanged.
//  5 Assert rst_n=0 at cycle 7 of INIT and mid-RUN after writes -> init restarts, 16 more busy cycles; all reads return 0.
//  6 RAM_DP_PARITY_EN: write 4'h7 to addr 2, read -> par_err=0; inject_par_flip(2), read -> par_err=1 with rd_data=4'h7.

Source files
------------

// File: rtl/ram_dp_param.sv
// Parametrised simple-dual-port synchronous RAM that clears itself to zero after reset.
// Optional even-parity protection per word is built when RAM_DP_PARITY_EN is defined.
`timescale 1ns/1ps
module ram_dp_param #(
  parameter int DATA_W     = 4,
  parameter int ADDR_W     = 4,
  parameter int DEPTH      = 16,
  parameter int READ_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              re,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              init_busy,
  output logic              par_err,
  output logic              dbg_state
);

  // Handshake: a read is accepted whenever re=1 in RUN; rd_valid=1 on the next cycle marks
  // rd_data as that read's result. There is no backpressure, and requests are ignored in INIT.

  localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t            state;
  logic [ADDR_W-1:0] init_ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic             wr_ok;
  logic             rd_ok;
  logic             collide;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] init_idx;

  assign wr_ok    = we && ({1'b0, wr_addr} < DEPTH_X);
  assign rd_ok    = {1'b0, rd_addr} < DEPTH_X;
  assign collide  = wr_ok && re && (wr_addr == rd_addr);
  assign wr_idx   = wr_addr[IDX_W-1:0];
  assign rd_idx   = rd_addr[IDX_W-1:0];
  assign init_idx = init_ptr[IDX_W-1:0];

  assign dbg_state = (state == ST_RUN);

  // Storage has no reset; the INIT sweep is what zeroes it.
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      mem[init_idx] <= '0;
    end else if (wr_ok) begin
      mem[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      init_ptr  <= '0;
      init_busy <= 1'b1;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          rd_valid <= 1'b0;
          if (init_ptr == LAST_PTR) begin
            state     <= ST_RUN;
            init_busy <= 1'b0;
          end else begin
            init_ptr <= init_ptr + 1'b1;
          end
        end
        ST_RUN: begin
          if (re) begin
            rd_valid <= 1'b1;
            if (!rd_ok) begin
              rd_data <= '0;
            end else if (collide && (READ_FIRST == 0)) begin
              rd_data <= wr_data;
            end else begin
              // Non-blocking storage update means this is the pre-write word on a collision.
              rd_data <= mem[rd_idx];
            end
          end else begin
            rd_valid <= 1'b0;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

`ifdef RAM_DP_PARITY_EN
  logic par_mem [DEPTH];
  logic par_err_q;

  // Plain always so the fault-injection task below may also update the parity bits.
  always @(posedge clk) begin
    if (state == ST_INIT) begin
      par_mem[init_idx] <= 1'b0;
    end else if (wr_ok) begin
      par_mem[wr_idx] <= ^wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_err_q <= 1'b0;
    end else if ((state == ST_RUN) && re && rd_ok && !(collide && (READ_FIRST == 0))) begin
      par_err_q <= par_mem[rd_idx] != (^mem[rd_idx]);
    end else begin
      par_err_q <= 1'b0;
    end
  end

  assign par_err = par_err_q;

`ifndef SYNTHESIS
  task automatic inject_par_flip(input logic [ADDR_W-1:0] addr);
    par_mem[addr[IDX_W-1:0]] = ~par_mem[addr[IDX_W-1:0]];
  endtask
`endif
`else
  assign par_err = 1'b0;
`endif

endmodule
